// File: rtl/controlador_trayectoria_pkg.sv
// State encoding shared by the trajectory record/playback controller and its bench.
// Pure declarations: no logic, no latency.
package controlador_trayectoria_pkg;

    localparam int ANCHO_ESTADO = 3;

    typedef enum logic [ANCHO_ESTADO-1:0] {
        EST_REPOSO    = 3'd0,
        EST_GRABANDO  = 3'd1,
        EST_LISTO     = 3'd2,
        EST_CORTANDO  = 3'd3,
        EST_PAUSA     = 3'd4,
        EST_TERMINADO = 3'd5
    } estado_t;

endpackage

// File: rtl/controlador_trayectoria_memoria_xy.sv
// Simple dual-port point buffer: synchronous write, registered read held until the next read.
// Read data appears one cycle after leer; no backpressure.
module memoria_xy #(
    parameter int ANCHO       = 12,
    parameter int PROFUNDIDAD = 64,
    localparam int ANCHO_DIR  = $clog2(PROFUNDIDAD)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 escribir,
    input  logic [ANCHO_DIR-1:0] dir_esc,
    input  logic [ANCHO-1:0]     dato_esc,
    input  logic                 leer,
    input  logic [ANCHO_DIR-1:0] dir_lec,
    output logic [ANCHO-1:0]     dato_lec
);

    logic [ANCHO-1:0] mem [PROFUNDIDAD];
    logic [ANCHO-1:0] dato_lec_q;
    logic [ANCHO-1:0] dato_lec_d;

    always_ff @(posedge clock) begin
        if (escribir) begin
            mem[dir_esc] <= dato_esc;
        end
    end

    // The read register only moves on leer so the playback point holds through a pause.
    always_comb begin
        dato_lec_d = dato_lec_q;
        if (leer) begin
            dato_lec_d = mem[dir_lec];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dato_lec_q <= '0;
        end else begin
            dato_lec_q <= dato_lec_d;
        end
    end

    assign dato_lec = dato_lec_q;

endmodule

// File: rtl/controlador_trayectoria.sv
// Records (x,y) samples and replays them with a valid/next handshake, one point per 2 cycles at most.
// Optional multi-pass playback under CONTROLADOR_TRAYECTORIA_REPETIR_EN (parameter REPETICIONES).
module controlador_trayectoria
    import controlador_trayectoria_pkg::*;
#(
    parameter int ANCHO_COORD  = 6,
    parameter int PROFUNDIDAD  = 64,
`ifdef CONTROLADOR_TRAYECTORIA_REPETIR_EN
    parameter int REPETICIONES = 2,
`endif
    localparam int ANCHO_CNT   = $clog2(PROFUNDIDAD + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iniciar_detener,
    input  logic                   pausar_reanudar,
    input  logic                   cancelar,
    input  logic                   cortar,
    input  logic                   guardar_xy,
    input  logic                   dato_siguiente,
    input  logic [ANCHO_COORD-1:0] x_sensor,
    input  logic [ANCHO_COORD-1:0] y_sensor,
    output logic [ANCHO_COORD-1:0] x_salida,
    output logic [ANCHO_COORD-1:0] y_salida,
    output logic                   dato_valido,
    output logic                   cortando,
    output logic                   corte_terminado,
    output logic                   memoria_llena,
    output logic                   desbordamiento,
    output logic [ANCHO_CNT-1:0]   num_puntos,
    output logic [2:0]             estado_actual
);

    localparam int ANCHO_DIR = $clog2(PROFUNDIDAD);

    estado_t                estado_q, estado_d;
    logic [ANCHO_CNT-1:0]   num_puntos_q, num_puntos_d;
    logic                   desbordamiento_q, desbordamiento_d;
    logic [ANCHO_DIR-1:0]   puntero_q, puntero_d;
    logic                   dato_valido_q, dato_valido_d;
    logic                   escribir, leer, llena, ultimo;
    logic [2*ANCHO_COORD-1:0] dato_lec;

`ifdef CONTROLADOR_TRAYECTORIA_REPETIR_EN
    localparam int ANCHO_PAS = $clog2(REPETICIONES + 1);
    logic [ANCHO_PAS-1:0]   pasada_q, pasada_d;
`endif

    assign llena  = (num_puntos_q == ANCHO_CNT'(PROFUNDIDAD));
    assign ultimo = (ANCHO_CNT'(puntero_q) == num_puntos_q - ANCHO_CNT'(1));

    always_comb begin
        estado_d         = estado_q;
        num_puntos_d     = num_puntos_q;
        desbordamiento_d = desbordamiento_q;
        puntero_d        = puntero_q;
        dato_valido_d    = 1'b0;
        escribir         = 1'b0;
        leer             = 1'b0;
`ifdef CONTROLADOR_TRAYECTORIA_REPETIR_EN
        pasada_d         = pasada_q;
`endif
        case (estado_q)
            EST_REPOSO: begin
                if (iniciar_detener) begin
                    estado_d         = EST_GRABANDO;
                    num_puntos_d     = '0;
                    desbordamiento_d = 1'b0;
                end
            end
            EST_GRABANDO: begin
                if (cancelar) begin
                    estado_d     = EST_REPOSO;
                    num_puntos_d = '0;
                end else if (iniciar_detener) begin
                    estado_d = (num_puntos_q != '0) ? EST_LISTO : EST_REPOSO;
                end else if (guardar_xy) begin
                    if (llena) begin
                        desbordamiento_d = 1'b1;
                    end else begin
                        escribir     = 1'b1;
                        num_puntos_d = num_puntos_q + ANCHO_CNT'(1);
                    end
                end
            end
            EST_LISTO: begin
                if (cancelar) begin
                    estado_d     = EST_REPOSO;
                    num_puntos_d = '0;
                end else if (iniciar_detener) begin
                    estado_d = EST_GRABANDO;
                end else if (cortar) begin
                    estado_d  = EST_CORTANDO;
                    puntero_d = '0;
`ifdef CONTROLADOR_TRAYECTORIA_REPETIR_EN
                    pasada_d  = '0;
`endif
                end
            end
            EST_CORTANDO: begin
                if (cancelar) begin
                    estado_d = EST_LISTO;
`ifdef CONTROLADOR_TRAYECTORIA_REPETIR_EN
                    pasada_d = '0;
`endif
                end else if (pausar_reanudar) begin
                    estado_d = EST_PAUSA;
                end else if (!dato_valido_q) begin
                    // Any cycle in CORTANDO without a valid point fetches the one at the pointer.
                    leer          = 1'b1;
                    dato_valido_d = 1'b1;
                end else if (dato_siguiente) begin
                    if (ultimo) begin
`ifdef CONTROLADOR_TRAYECTORIA_REPETIR_EN
                        if (pasada_q == ANCHO_PAS'(REPETICIONES - 1)) begin
                            estado_d = EST_TERMINADO;
                        end else begin
                            pasada_d  = pasada_q + ANCHO_PAS'(1);
                            puntero_d = '0;
                        end
`else
                        estado_d = EST_TERMINADO;
`endif
                    end else begin
                        puntero_d = puntero_q + ANCHO_DIR'(1);
                    end
                end else begin
                    dato_valido_d = 1'b1;
                end
            end
            EST_PAUSA: begin
                if (cancelar) begin
                    estado_d = EST_LISTO;
`ifdef CONTROLADOR_TRAYECTORIA_REPETIR_EN
                    pasada_d = '0;
`endif
                end else if (pausar_reanudar) begin
                    estado_d = EST_CORTANDO;
                end
            end
            EST_TERMINADO: estado_d = EST_LISTO;
            default:       estado_d = EST_REPOSO;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q         <= EST_REPOSO;
            num_puntos_q     <= '0;
            desbordamiento_q <= 1'b0;
            puntero_q        <= '0;
            dato_valido_q    <= 1'b0;
`ifdef CONTROLADOR_TRAYECTORIA_REPETIR_EN
            pasada_q         <= '0;
`endif
        end else begin
            estado_q         <= estado_d;
            num_puntos_q     <= num_puntos_d;
            desbordamiento_q <= desbordamiento_d;
            puntero_q        <= puntero_d;
            dato_valido_q    <= dato_valido_d;
`ifdef CONTROLADOR_TRAYECTORIA_REPETIR_EN
            pasada_q         <= pasada_d;
`endif
        end
    end

    memoria_xy #(
        .ANCHO       (2 * ANCHO_COORD),
        .PROFUNDIDAD (PROFUNDIDAD)
    ) u_memoria (
        .clock    (clock),
        .reset    (reset),
        .escribir (escribir),
        .dir_esc  (num_puntos_q[ANCHO_DIR-1:0]),
        .dato_esc ({x_sensor, y_sensor}),
        .leer     (leer),
        .dir_lec  (puntero_q),
        .dato_lec (dato_lec)
    );

    assign x_salida        = dato_lec[2*ANCHO_COORD-1:ANCHO_COORD];
    assign y_salida        = dato_lec[ANCHO_COORD-1:0];
    assign dato_valido     = dato_valido_q;
    assign cortando        = (estado_q == EST_CORTANDO) || (estado_q == EST_PAUSA);
    assign corte_terminado = (estado_q == EST_TERMINADO);
    assign memoria_llena   = llena;
    assign desbordamiento  = desbordamiento_q;
    assign num_puntos      = num_puntos_q;
    assign estado_actual   = estado_q;

endmodule
